// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package : mem_port_arbiter_pkg
//  Shared encodings for the CPU/DMA memory port arbiter.
//  Revision: 1.0
// ============================================================================
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic OWN_CPU  = 1'b0;
   localparam logic OWN_DMA  = 1'b1;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Wait counter width; a zero-wait build still needs a 1-bit counter.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles <= 0) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_port_arbiter
//  Round-robin arbiter sharing one memory port between CPU and DMA, with a
//  fixed wait-state count per access. All outputs are registered.
//  Revision: 1.0
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_rw,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_done,
   input  logic          d_req,
   input  logic          d_rw,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_rw,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic          busy
);

   localparam int            CW       = cnt_width(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            owner_q, owner_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_rw_q, mem_rw_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            c_done_q, c_done_d;
   logic            d_done_q, d_done_d;
   logic            busy_q, busy_d;
   logic            winner;

   // On a tie the requester that did not hold the last grant wins.
   always_comb begin
      if (c_req && d_req) begin
         winner = ~owner_q;
      end else if (d_req) begin
         winner = OWN_DMA;
      end else begin
         winner = OWN_CPU;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      mem_en_d    = 1'b0;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      c_done_d    = 1'b0;
      d_done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (c_req || d_req) begin
               state_d  = ST_ACCESS;
               owner_d  = winner;
               cnt_d    = CNT_INIT;
               mem_en_d = 1'b1;
               if (winner == OWN_DMA) begin
                  mem_rw_d    = d_rw;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  mem_rw_d    = c_rw;
                  mem_addr_d  = c_addr;
                  mem_wdata_d = c_wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d    = cnt_q - CW'(1);
               mem_en_d = 1'b1;
            end else begin
               state_d = ST_DONE;
               if (mem_rw_q == RW_READ) begin
                  rdata_d = mem_rdata;
               end
               c_done_d = (owner_q == OWN_CPU);
               d_done_d = (owner_q == OWN_DMA);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         owner_q     <= OWN_DMA;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         c_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         mem_en_q    <= mem_en_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         c_done_q    <= c_done_d;
         d_done_q    <= d_done_d;
         busy_q      <= busy_d;
      end
   end

   assign c_done    = c_done_q;
   assign d_done    = d_done_q;
   assign rdata     = rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_rw    = mem_rw_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign owner     = owner_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Testbench : tb_mem_port_arbiter
//  Directed and random CPU/DMA traffic scored against a transaction model.
//  Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int WAIT = 2;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        imm;
      logic        drop;
   } op_t;

   typedef struct {
      logic        who;
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          n;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        c_req = 1'b0, c_rw = 1'b0, d_req = 1'b0, d_rw = 1'b0;
   logic [15:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
   logic [15:0] mem_rdata = '0;
   logic        c_done, d_done, mem_en, mem_rw, owner, busy;
   logic [15:0] rdata, mem_addr, mem_wdata;

   mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr), .c_wdata(c_wdata), .c_done(c_done),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
      .rdata(rdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return (a == 16'h0040) ? 16'hBEEF : ((a ^ 16'h5A3C) + 16'h0101);
   endfunction

   function automatic logic pick(input logic c, input logic d, input logic last);
      if (c && d) return ~last;
      return d ? OWN_DMA : OWN_CPU;
   endfunction

   // Memory: returns a function of the address while accessed, noise otherwise.
   initial forever begin
      @(negedge clk);
      mem_rdata = mem_en ? mem_fn(mem_addr) : 16'($urandom);
   end

   // Transaction model: port is free again WAIT+3 cycles after a grant.
   exp_t exp_mem [256];
   int   wr_ptr = 0;
   int   cyc = 0;
   int   next_free = 0;
   int   c_grants = 0, d_grants = 0;
   logic m_owner = OWN_DMA;

   initial begin : model
      logic win;
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_owner   = OWN_DMA;
            next_free = 0;
         end else if (cyc >= next_free && (c_req || d_req)) begin
            win = pick(c_req, d_req, m_owner);
            exp_mem[wr_ptr % 256] = '{who: win, rw: (win ? d_rw : c_rw),
                                      addr: (win ? d_addr : c_addr),
                                      wdata: (win ? d_wdata : c_wdata), n: cyc};
            wr_ptr    = wr_ptr + 1;
            m_owner   = win;
            next_free = cyc + WAIT + 3;
            if (win == OWN_DMA) d_grants = d_grants + 1;
            else                c_grants = c_grants + 1;
         end
         cyc = cyc + 1;
      end
   end

   // Monitor / scoreboard
   int          errors = 0, checks = 0;
   int          rd_ptr = 0;
   logic [15:0] m_rdata = '0;
   logic        end_req = 1'b0;
   logic        timeout_flag = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin : mon
      exp_t e;
      logic have, in_en, is_done;
      forever begin
         @(negedge clk or negedge rst);
         if (!rst) begin
            #1;
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_c_done", 32'(c_done), 32'd0);
            chk("rst_d_done", 32'(d_done), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_mem_rw", 32'(mem_rw), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_owner", 32'(owner), 32'd1);
            rd_ptr  = wr_ptr;
            m_rdata = '0;
         end else begin
            have    = (wr_ptr != rd_ptr);
            e       = exp_mem[rd_ptr % 256];
            in_en   = have && (cyc >= e.n + 1) && (cyc <= e.n + WAIT + 1);
            is_done = have && (cyc == e.n + WAIT + 2);
            chk("mem_en", 32'(mem_en), 32'(in_en));
            chk("busy", 32'(busy), 32'(in_en || is_done));
            chk("c_done", 32'(c_done), 32'(is_done && e.who == OWN_CPU));
            chk("d_done", 32'(d_done), 32'(is_done && e.who == OWN_DMA));
            chk("owner", 32'(owner), 32'(m_owner));
            if (in_en) begin
               chk("mem_rw", 32'(mem_rw), 32'(e.rw));
               chk("mem_addr", 32'(mem_addr), 32'(e.addr));
               chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
            if (is_done) begin
               if (e.rw == RW_READ) m_rdata = mem_fn(e.addr);
               rd_ptr = rd_ptr + 1;
            end
            chk("rdata", 32'(rdata), 32'(m_rdata));
            if (end_req) begin
               chk("drain", {30'd0, timeout_flag, (wr_ptr != rd_ptr)}, 32'd0);
               $display("Result: errors=%0d of %0d checks", errors, checks);
               $finish;
            end
         end
      end
   end

   // Requester agents, driven from the main process only.
   op_t  cq[$], dq[$];
   logic c_busy = 1'b0, d_busy = 1'b0, c_drop = 1'b0, d_drop = 1'b0;
   int   c_seq = 0, d_seq = 0;

   task automatic issue_c();
      op_t o;
      o = cq.pop_front();
      c_req = 1'b1; c_rw = o.rw; c_addr = o.addr; c_wdata = o.wdata;
      c_drop = o.drop; c_busy = 1'b1; c_seq = c_grants;
   endtask

   task automatic issue_d();
      op_t o;
      o = dq.pop_front();
      d_req = 1'b1; d_rw = o.rw; d_addr = o.addr; d_wdata = o.wdata;
      d_drop = o.drop; d_busy = 1'b1; d_seq = d_grants;
   endtask

   task automatic step();
      @(negedge clk);
      if (c_busy) begin
         if (c_done) begin
            c_busy = 1'b0;
            if (cq.size() > 0 && cq[0].imm) issue_c();
            else c_req = 1'b0;
         end else if (c_grants != c_seq) begin
            if (c_drop) c_req = 1'b0;
            c_rw = 1'($urandom); c_addr = 16'($urandom); c_wdata = 16'($urandom);
         end
      end else if (cq.size() > 0 && (cq[0].imm || $urandom_range(0, 2) == 0)) begin
         issue_c();
      end
      if (d_busy) begin
         if (d_done) begin
            d_busy = 1'b0;
            if (dq.size() > 0 && dq[0].imm) issue_d();
            else d_req = 1'b0;
         end else if (d_grants != d_seq) begin
            if (d_drop) d_req = 1'b0;
            d_rw = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
         end
      end else if (dq.size() > 0 && (dq[0].imm || $urandom_range(0, 2) == 0)) begin
         issue_d();
      end
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((cq.size() > 0 || dq.size() > 0 || c_busy || d_busy) && k < budget) begin
         step();
         k = k + 1;
      end
      if (cq.size() > 0 || dq.size() > 0 || c_busy || d_busy) timeout_flag = 1'b1;
      repeat (2) step();
   endtask

   task automatic clear_agents();
      c_req = 1'b0; d_req = 1'b0; c_busy = 1'b0; d_busy = 1'b0;
      c_drop = 1'b0; d_drop = 1'b0;
   endtask

   initial begin : main
      int k;
      rst = 1'b0;
      repeat (3) step();
      #2 rst = 1'b1;

      // Both requesters held together: expect alternating grants.
      cq.push_back('{1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0});
      cq.push_back('{1'b0, 16'h0012, 16'h5555, 1'b1, 1'b0});
      dq.push_back('{1'b0, 16'h0020, 16'hAAAA, 1'b1, 1'b0});
      dq.push_back('{1'b1, 16'h0022, 16'h0000, 1'b1, 1'b0});
      drain(200);

      cq.push_back('{RW_READ, 16'h0040, 16'h0000, 1'b1, 1'b0});
      drain(100);
      dq.push_back('{RW_WRITE, 16'h0100, 16'h1234, 1'b1, 1'b0});
      drain(100);
      cq.push_back('{RW_READ, 16'h0222, 16'h0000, 1'b1, 1'b1});
      drain(100);

      // Reset in the middle of an access.
      cq.push_back('{RW_READ, 16'h0040, 16'h0000, 1'b1, 1'b0});
      k = 0;
      while (!mem_en && k < 20) begin
         step();
         k = k + 1;
      end
      if (!mem_en) timeout_flag = 1'b1;
      step();
      #2 rst = 1'b0;
      clear_agents();
      repeat (3) step();
      #2 rst = 1'b1;
      cq.push_back('{RW_WRITE, 16'h0300, 16'hCAFE, 1'b1, 1'b0});
      drain(100);

      for (int i = 0; i < 80; i++) begin
         op_t o;
         o.rw    = 1'($urandom);
         o.addr  = 16'($urandom);
         o.wdata = 16'($urandom);
         o.imm   = ($urandom_range(0, 3) == 0);
         o.drop  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 1) == 1) cq.push_back(o);
         else dq.push_back(o);
      end
      drain(20000);

      end_req = 1'b1;
      repeat (5) @(negedge clk);
      $display("FAIL end: monitor did not reach summary");
      $fatal(1);
   end

endmodule
`default_nettype wire
